// File: rtl/decimal_pp_accumulator_if.sv
// Stream bundle for decimal_pp_accumulator.
//   Input side : in_valid/in_ready handshake, in_first marks an operation's
//                first partial product, in_pp is the BCD-4221 partial product.
//   Output side: out_valid/out_ready handshake, out_s/out_h redundant result
//                (out_h has weight 2), ovf sticky MSD overflow, err_seq pulse.
// master = producer/consumer environment, slave = accumulator.
interface decimal_pp_accumulator_if #(
  parameter int DIGITS = 11
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_first;
  logic [4*DIGITS-1:0]   in_pp;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_s;
  logic [4*DIGITS-1:0]   out_h;
  logic                  ovf;
  logic                  err_seq;

  modport master (
    output in_valid, in_first, in_pp, out_ready,
    input  in_ready, out_valid, out_s, out_h, ovf, err_seq
  );

  modport slave (
    input  in_valid, in_first, in_pp, out_ready,
    output in_ready, out_valid, out_s, out_h, ovf, err_seq
  );
endinterface

// File: rtl/decimal_pp_accumulator.sv
// Sequential decimal partial-product accumulator.
// Accepts NUM_PP BCD-4221 partial products per operation (one per beat) and
// reduces them into a carry-save pair (S, H) with S + 2H == sum of the beats
// mod 10^DIGITS. Each beat: H is doubled (4221->5211 recode, 1-bit left
// shift), then S, 2H and the new PP are combined by a bitwise 3:2 CSA.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - decimal_pp_accumulator_if.slave (input/output streams, ovf, err_seq)
module decimal_pp_accumulator #(
  parameter int DIGITS = 11,
  parameter int NUM_PP = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  decimal_pp_accumulator_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(NUM_PP + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   acc_s, acc_s_n;
  logic [W-1:0]   acc_h, acc_h_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           ovf, ovf_n;
  logic           err_n, err_q;
  logic           out_valid_q;

  logic [W-1:0]   rec;
  logic [W-1:0]   d2;
  logic [W-1:0]   csa_s;
  logic [W-1:0]   csa_h;
  logic           accept;

  // Any 4221 pattern (value 0..9) to a 5211 code whose low three bits,
  // shifted left, form a 4221 digit and whose MSB carries weight 10.
  function automatic logic [3:0] to_5211(input logic [3:0] d);
    logic [3:0] v;
    v = {d[3], 2'b00} + {2'b00, d[2], 1'b0} + {2'b00, d[1], 1'b0} + {3'b000, d[0]};
    case (v)
      4'd0:    return 4'b0000;
      4'd1:    return 4'b0001;
      4'd2:    return 4'b0100;
      4'd3:    return 4'b0101;
      4'd4:    return 4'b0111;
      4'd5:    return 4'b1000;
      4'd6:    return 4'b1001;
      4'd7:    return 4'b1100;
      4'd8:    return 4'b1101;
      4'd9:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  always_comb begin
    rec = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      rec[4*i +: 4] = to_5211(acc_h[4*i +: 4]);
    end
  end

  // Doubling: the shift moves each digit's 5211 MSB into the next digit's LSB.
  assign d2     = {rec[W-2:0], 1'b0};
  assign csa_s  = acc_s ^ d2 ^ bus.in_pp;
  assign csa_h  = (acc_s & d2) | (acc_s & bus.in_pp) | (d2 & bus.in_pp);
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_n = state;
    acc_s_n = acc_s;
    acc_h_n = acc_h;
    cnt_n   = cnt;
    ovf_n   = ovf;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.in_first) begin
            acc_s_n = bus.in_pp;
            acc_h_n = '0;
            cnt_n   = CW'(1);
            ovf_n   = 1'b0;
            state_n = ACC;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ACC: begin
        if (accept) begin
          if (bus.in_first) begin
            // Restart mid-operation: previous partial sum is dropped.
            acc_s_n = bus.in_pp;
            acc_h_n = '0;
            cnt_n   = CW'(1);
            ovf_n   = 1'b0;
            err_n   = 1'b1;
          end else begin
            acc_s_n = csa_s;
            acc_h_n = csa_h;
            cnt_n   = cnt + CW'(1);
            ovf_n   = ovf | rec[W-1];
            if (cnt_n == CW'(NUM_PP)) state_n = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_s       <= '0;
      acc_h       <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      acc_s       <= acc_s_n;
      acc_h       <= acc_h_n;
      cnt         <= cnt_n;
      ovf         <= ovf_n;
      err_q       <= err_n;
      out_valid_q <= (state_n == DONE);
    end
  end

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = acc_s;
  assign bus.out_h     = acc_h;
  assign bus.ovf       = ovf;
  assign bus.err_seq   = err_q;

endmodule

// File: tb/tb_decimal_pp_accumulator.sv
// Scoreboard bench for decimal_pp_accumulator (DIGITS=11, NUM_PP=5).
module tb_decimal_pp_accumulator;

  localparam int       DIGITS = 11;
  localparam int       NUM_PP = 5;
  localparam int       W      = 4 * DIGITS;
  localparam longint   MODV   = 64'd100000000000;

  typedef struct {
    longint val;
    bit     ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   checks;
  int   errors;
  int   err_pulses;

  decimal_pp_accumulator_if #(.DIGITS(DIGITS)) bus ();

  decimal_pp_accumulator #(.DIGITS(DIGITS), .NUM_PP(NUM_PP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] enc(input longint v);
    logic [3:0]   tbl [10];
    logic [W-1:0] r;
    longint       x;
    tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000,
            4'b1001, 4'b1010, 4'b1011, 4'b1110, 4'b1111};
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = tbl[int'(x % 10)];
      x = x / 10;
    end
    return r;
  endfunction

  function automatic longint dec(input logic [W-1:0] v);
    longint acc;
    longint p;
    acc = 0;
    p   = 1;
    for (int i = 0; i < DIGITS; i++) begin
      acc += p * (4 * longint'(v[4*i+3]) + 2 * longint'(v[4*i+2]) +
                  2 * longint'(v[4*i+1]) + longint'(v[4*i]));
      p *= 10;
    end
    return acc;
  endfunction

  function automatic longint result_val();
    return (dec(bus.out_s) + 2 * dec(bus.out_h)) % MODV;
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.err_seq === 1'b1) err_pulses++;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got value %0d expected no output", result_val());
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result_value", result_val(), e.val);
          chk("result_ovf", longint'(bus.ovf), longint'(e.ovf));
        end
      end
    end
  end

  task automatic drive_beat(input bit first, input longint v, output int waited);
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.in_pp    = enc(v);
    waited       = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        waited = n;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    if (waited < 0) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic send5(input longint a, input longint b, input longint c,
                       input longint d, input longint e);
    int w;
    drive_beat(1'b1, a, w);
    drive_beat(1'b0, b, w);
    drive_beat(1'b0, c, w);
    drive_beat(1'b0, d, w);
    drive_beat(1'b0, e, w);
  endtask

  task automatic push(input longint val, input bit o);
    exp_t e;
    e.val = val;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", longint'(sb.size()), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int     w;
    int     e0;
    checks       = 0;
    errors       = 0;
    err_pulses   = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_pp    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", longint'(bus.in_ready), 1);
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_ovf", longint'(bus.ovf), 0);
    chk("reset_err_seq", longint'(bus.err_seq), 0);
    chk("reset_out_s", dec(bus.out_s), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1+2+3+4+5 = 15, output one cycle after the fifth accept
    push(15, 1'b0);
    send5(1, 2, 3, 4, 5);
    @(negedge clk);
    chk("latency_out_valid", longint'(bus.out_valid), 1);
    drain();

    // Five all-nines beats: MSD overflow on doubling
    push(64'd99999999995, 1'b1);
    send5(64'd99999999999, 64'd99999999999, 64'd99999999999,
          64'd99999999999, 64'd99999999999);
    drain();

    // Back-pressure: result held for 10 cycles, input ignored
    bus.out_ready = 1'b0;
    push(1500, 1'b0);
    send5(100, 200, 300, 400, 500);
    for (int n = 0; n < 20; n++) begin
      if (bus.out_valid) break;
      @(negedge clk);
    end
    e0 = err_pulses;
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.in_pp    = enc(7);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("hold_out_valid", longint'(bus.out_valid), 1);
      chk("hold_in_ready", longint'(bus.in_ready), 0);
      chk("hold_value", result_val(), 1500);
    end
    chk("hold_no_err", longint'(err_pulses - e0), 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready_low", longint'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    push(5, 1'b0);
    drive_beat(1'b1, 1, w);
    chk("release_accept_wait", longint'(w), 0);
    drive_beat(1'b0, 1, w);
    drive_beat(1'b0, 1, w);
    drive_beat(1'b0, 1, w);
    drive_beat(1'b0, 1, w);
    drain();

    // Restart on beat 3: 7 + 1+1+1+1 = 11
    e0 = err_pulses;
    push(11, 1'b0);
    drive_beat(1'b1, 3, w);
    drive_beat(1'b0, 4, w);
    drive_beat(1'b1, 7, w);
    drive_beat(1'b0, 1, w);
    drive_beat(1'b0, 1, w);
    drive_beat(1'b0, 1, w);
    drive_beat(1'b0, 1, w);
    drain();
    chk("restart_err_pulses", longint'(err_pulses - e0), 1);

    // Stray beat in IDLE, then a normal operation
    e0 = err_pulses;
    drive_beat(1'b0, 9, w);
    @(negedge clk);
    chk("stray_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    chk("stray_err_pulses", longint'(err_pulses - e0), 1);
    push(10, 1'b0);
    send5(2, 2, 2, 2, 2);
    drain();

    // Asynchronous reset after beat 2
    drive_beat(1'b1, 1234, w);
    drive_beat(1'b0, 5678, w);
    rst_n = 1'b0;
    #1;
    chk("async_out_s", dec(bus.out_s), 0);
    chk("async_out_h", dec(bus.out_h), 0);
    chk("async_in_ready", longint'(bus.in_ready), 1);
    chk("async_out_valid", longint'(bus.out_valid), 0);
    chk("async_ovf", longint'(bus.ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(50, 1'b0);
    send5(10, 10, 10, 10, 10);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
